// File: rtl/dpu_mac_pkg.sv
// Shared width constants, accumulator limits and operand types for the DPU MAC lanes.
package dpu_mac_pkg;
   localparam int INT8_W = 8;
   localparam int ACC_W  = 32;
   localparam int PROD_W = 16;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef logic signed [INT8_W-1:0] int8_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/sat_add_acc.sv
// Combinational signed accumulator add with overflow detect and optional clamp.
module sat_add_acc
   import dpu_mac_pkg::*;
#(
   parameter int ACC_W    = dpu_mac_pkg::ACC_W,
   parameter bit SATURATE = 1'b0
) (
   input  logic signed [ACC_W-1:0] a,
   input  logic signed [ACC_W-1:0] b,
   output logic signed [ACC_W-1:0] sum,
   output logic                    overflow
);

   localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] sum_ext;

   // A wide result escapes the ACC_W range exactly when its top two bits disagree;
   // the top bit then carries the true sign, which picks the clamp rail.
   function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [ACC_W:0] s);
      logic signed [ACC_W-1:0] r;
      r = s[ACC_W-1:0];
      if (s[ACC_W] != s[ACC_W-1]) begin
         r = s[ACC_W] ? SUM_MIN : SUM_MAX;
      end
      return r;
   endfunction

   always_comb begin
      sum_ext  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      overflow = sum_ext[ACC_W] != sum_ext[ACC_W-1];
      sum      = SATURATE ? clamp_acc(sum_ext) : sum_ext[ACC_W-1:0];
   end

endmodule

// File: rtl/mac_int8.sv
// Single-lane signed INT8 multiply-accumulate with an external accumulator and 1-cycle latency.
module mac_int8
   import dpu_mac_pkg::*;
#(
   parameter int A_W      = dpu_mac_pkg::INT8_W,
   parameter int W_W      = dpu_mac_pkg::INT8_W,
   parameter int ACC_W    = dpu_mac_pkg::ACC_W,
   parameter bit SATURATE = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid,
   input  logic signed [W_W-1:0]   weight,
   input  logic signed [A_W-1:0]   activation,
   input  logic signed [ACC_W-1:0] acc_in,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    done,
   output logic                    overflow
);

   localparam int PW = A_W + W_W;

   logic signed [PW-1:0]    prod_p0;
   logic signed [ACC_W-1:0] prod_ext_p0;
   logic signed [ACC_W-1:0] sum_p0;
   logic                    ovf_p0;

   logic signed [ACC_W-1:0] acc_p1;
   logic                    ovf_p1;
   logic                    vld_p1;

   // p0: full-precision product, sign-extended, added to the caller's partial sum
   always_comb begin
      prod_p0     = weight * activation;
      prod_ext_p0 = {{(ACC_W-PW){prod_p0[PW-1]}}, prod_p0};
   end

   sat_add_acc #(
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
   ) u_add (
      .a       (acc_in),
      .b       (prod_ext_p0),
      .sum     (sum_p0),
      .overflow(ovf_p0)
   );

   // p1: result register; operands are captured only on valid so idle-cycle junk never lands
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p1 <= '0;
         ovf_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= valid;
         if (valid) begin
            acc_p1 <= sum_p0;
            ovf_p1 <= ovf_p0;
         end
      end
   end

   assign acc_out  = acc_p1;
   assign overflow = ovf_p1;
   assign done     = vld_p1;

endmodule

// File: tb/tb_mac_int8.sv
// Bench for mac_int8: wrap and saturate instances side by side against a longint reference model.
module tb_mac_int8;

   logic               clk;
   logic               rst;
   logic               valid;
   logic signed [7:0]  weight;
   logic signed [7:0]  activation;
   logic signed [31:0] acc_in;

   logic signed [31:0] acc_w, acc_s;
   logic               done_w, done_s, ovf_w, ovf_s;

   int tests_run;
   int tests_failed;

   logic signed [31:0] exp_acc_w, exp_acc_s;
   logic               exp_done, exp_ovf;

   mac_int8 #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .valid(valid), .weight(weight), .activation(activation),
      .acc_in(acc_in), .acc_out(acc_w), .done(done_w), .overflow(ovf_w)
   );

   mac_int8 #(.SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .valid(valid), .weight(weight), .activation(activation),
      .acc_in(acc_in), .acc_out(acc_s), .done(done_s), .overflow(ovf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
      end
   endtask

   // Reference: exact sum in 64-bit arithmetic, then range test, wrap and clamp from the rules.
   task automatic model(input logic r, input logic v, input int w, input int a, input longint acc);
      longint s;
      if (r) begin
         exp_acc_w = 0; exp_acc_s = 0; exp_ovf = 0; exp_done = 0;
      end else if (v) begin
         s = acc + longint'(w) * longint'(a);
         exp_done = 1;
         exp_ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         exp_acc_w = 32'(s);
         if (s > 64'sd2147483647)       exp_acc_s = 32'sh7FFFFFFF;
         else if (s < -64'sd2147483648) exp_acc_s = 32'sh80000000;
         else                           exp_acc_s = 32'(s);
      end else begin
         exp_done = 0;
      end
   endtask

   task automatic step(input string tag, input logic r, input logic v,
                       input int w, input int a, input int acc);
      @(negedge clk);
      rst = r; valid = v; weight = 8'(w); activation = 8'(a); acc_in = acc;
      model(r, v, int'($signed(8'(w))), int'($signed(8'(a))), longint'(acc));
      @(posedge clk);
      #1;
      check({tag, ".acc_wrap"}, acc_w,  exp_acc_w);
      check({tag, ".acc_sat"},  acc_s,  exp_acc_s);
      check({tag, ".done_wrap"}, {31'd0, done_w}, {31'd0, exp_done});
      check({tag, ".done_sat"},  {31'd0, done_s}, {31'd0, exp_done});
      check({tag, ".ovf_wrap"},  {31'd0, ovf_w},  {31'd0, exp_ovf});
      check({tag, ".ovf_sat"},   {31'd0, ovf_s},  {31'd0, exp_ovf});
   endtask

   initial begin
      int w, a, acc;
      logic r, v;
      tests_run = 0; tests_failed = 0;
      rst = 1'b1; valid = 1'b0; weight = '0; activation = '0; acc_in = '0;
      exp_acc_w = 0; exp_acc_s = 0; exp_ovf = 0; exp_done = 0;

      step("reset", 1, 0, 0, 0, 0);
      step("reset2", 1, 1, 3, 3, 3);

      step("basic", 0, 1, 10, 20, 0);
      step("basic_idle", 0, 0, 7, 9, 55);
      check("basic_hold", acc_w, 32'sd200);

      step("neg", 0, 1, -10, 20, 0);
      check("neg_value", acc_w, -32'sd200);
      step("maxpos", 0, 1, 127, 127, 0);
      step("minmin", 0, 1, -128, -128, 0);
      check("minmin_value", acc_s, 32'sd16384);
      step("acc", 0, 1, 50, 50, 1000);
      check("acc_value", acc_w, 32'sd3500);

      step("chain0", 0, 1, 2, 3, 0);
      step("chain1", 0, 1, 4, 5, exp_acc_w);
      check("chain_value", acc_w, 32'sd26);

      step("ovf_pos", 0, 1, 1, 1, 32'sh7FFFFFFF);
      step("ovf_clear", 0, 1, 1, 1, 0);
      step("sat_pos", 0, 1, 127, 127, 2147483600);
      step("sat_neg", 0, 1, -128, 127, -2147483600);
      step("hold_idle0", 0, 0, 99, -5, 12345);
      step("hold_idle1", 0, 0, -77, 33, -9);

      step("pre_rst", 0, 1, 1, 1, 41);
      step("rst_mid", 1, 1, 10, 20, 0);
      step("post_rst", 0, 1, 10, 20, 0);

      for (int i = 0; i < 60; i++) begin
         w = int'($signed(8'($urandom)));
         a = int'($signed(8'($urandom)));
         case ($urandom_range(0, 3))
            0: acc = 32'sh7FFFFFFF - int'($urandom_range(0, 20000));
            1: acc = 32'sh80000000 + int'($urandom_range(0, 20000));
            2: acc = exp_acc_w;
            default: acc = int'($urandom);
         endcase
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 15) == 0);
         step("rand", r, v, w, a, acc);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_int8.md
Name: mac_int8

Overview:
Single-lane signed INT8 multiply-accumulate primitive for the DPU datapath. Each valid cycle computes acc_in + weight*activation into a registered 32-bit result with a one-cycle done strobe. The accumulator is external: the caller feeds back acc_out or supplies a new partial sum. Tiled conv/matmul arrays instantiate it once per lane.

Parameters:
A_W, 8, activation width (signed)
W_W, 8, weight width (signed)
ACC_W, 32, accumulator input/output width (signed)
SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to signed ACC_W limits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
valid  input  1  operands valid this cycle
weight  input  W_W  signed weight
activation  input  A_W  signed activation
acc_in  input  ACC_W  signed partial sum to add
acc_out  output  ACC_W  signed registered result
done  output  1  one-cycle strobe: acc_out updated
overflow  output  1  registered; signed add overflowed on the last accepted op

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising edge with rst=1, acc_out=0, done=0, overflow=0. rst has priority over valid.
- Product: full-precision signed weight*activation, A_W+W_W bits (16), sign-extended to ACC_W. The product never overflows; -128*-128 = 16384.
- Sum: acc_in + sign-extended product, computed at ACC_W+1 bits.
- Overflow: set when the ACC_W+1 result is outside the signed ACC_W range, i.e. both operands have the same sign and the result sign differs.
- SATURATE=0: acc_out takes the low ACC_W bits (wrap).
- SATURATE=1: acc_out clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Latency 1: on a clock edge sampling valid=1, acc_out, overflow and done=1 update together. The result is visible the cycle after valid.
- valid=0: done=0 next cycle. acc_out and overflow hold their last values.
- Back-to-back valid: one result per cycle, done stays high continuously, full throughput.
- No backpressure, no ready signal. Operands are sampled only when valid=1; X on operands while valid=0 must not propagate.
- Reset asserted mid-stream: the op in that cycle is discarded and outputs go to reset values.
- Fully synchronous, with no combinational path from inputs to outputs.

Decomposition:
- Shared package dpu_mac_pkg holds:
  - width constants: INT8_W=8, ACC_W=32, PROD_W=16
  - ACC_MAX and ACC_MIN localparams
  - typedefs int8_t (logic signed [7:0]) and acc_t (logic signed [31:0])
- One natural sub-module: sat_add_acc. It is combinational signed add with overflow detect and optional clamp, reused by the adder trees.
- Multiply and register stage stay inline in mac_int8.

Test Plan:
- Basic: W=10, A=20, acc_in=0, valid 1 cycle -> next cycle acc_out=200, done=1, overflow=0; done=0 the following cycle, acc_out holds 200.
- Signs: W=-10, A=20, acc_in=0 -> -200. W=127, A=127, acc_in=0 -> 16129. W=-128, A=-128 -> 16384.
- Accumulate: W=50, A=50, acc_in=1000 -> 3500. Back-to-back chain (2,3,0), (4,5,acc_out) on consecutive cycles -> 6 then 26, done high both cycles.
- Overflow wrap (SATURATE=0): acc_in=2147483647, W=1, A=1 -> acc_out=-2147483648, overflow=1. Next op W=1, A=1, acc_in=0 -> 1, overflow=0.
- Saturate (SATURATE=1): acc_in=2147483600, W=127, A=127 -> 2147483647, overflow=1. acc_in=-2147483600, W=-128, A=127 -> -2147483648, overflow=1.
- Reset: rst=1 in the same cycle as valid=1 with W=10, A=20 -> acc_out=0, done=0, overflow=0. Held-value check: valid=0 with changing operands -> acc_out unchanged.
